// File: rtl/pll_lock_sequencer_if.sv
// rtl/pll_lock_sequencer_if.sv - PLL lock sequencer control/status bundle
interface pll_lock_sequencer_if;
    logic       pll_locked;
    logic       req_relock;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [3:0] retry_cnt;

    modport master (
        output pll_locked,
        output req_relock,
        input  pll_rst,
        input  sys_rst_n,
        input  ready,
        input  fail,
        input  lock_lost,
        input  retry_cnt
    );

    modport slave (
        input  pll_locked,
        input  req_relock,
        output pll_rst,
        output sys_rst_n,
        output ready,
        output fail,
        output lock_lost,
        output retry_cnt
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset pulse, lock filter, retry and downstream reset release
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_FILTER  = 64,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned MAX_RETRIES  = 7
) (
    input logic                 refclk,
    input logic                 rst_n,
    pll_lock_sequencer_if.slave bus
);
    localparam int RST_W  = $clog2(RST_CYCLES + 1);
    localparam int FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);

    // Each counter fires on the edge that would take it to its parameter value.
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRIES);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_FILTER    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [RST_W-1:0]  rst_cnt;
    logic [FILT_W-1:0] filt_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [3:0]        retry_q;
    logic              sync_meta;
    logic              locked_s;
    logic              pll_rst_q;
    logic              sys_rst_n_q;
    logic              ready_q;
    logic              fail_q;
    logic              lock_lost_q;
    logic              tmo_hit;
    logic              timeout;
    logic              relock_ok;
    logic              lost_evt;
    logic              win_cur;
    logic              win_nxt;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= bus.pll_locked;
            locked_s  <= sync_meta;
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign win_cur = (state == S_WAIT_LOCK) || (state == S_FILTER);
    assign win_nxt = (state_nxt == S_WAIT_LOCK) || (state_nxt == S_FILTER);

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        relock_ok = 1'b0;
        lost_evt  = 1'b0;
        case (state)
            S_RESET_PLL: begin
                if (rst_cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (tmo_hit)       timeout   = 1'b1;
                else if (locked_s) state_nxt = S_FILTER;
            end
            S_FILTER: begin
                // Timeout wins even when the filter would complete on this edge.
                if (tmo_hit)                    timeout   = 1'b1;
                else if (!locked_s)             state_nxt = S_WAIT_LOCK;
                else if (filt_cnt == FILT_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!locked_s) begin
                    lost_evt  = 1'b1;
                    state_nxt = S_RESET_PLL;
                end else if (bus.req_relock) begin
                    relock_ok = 1'b1;
                    state_nxt = S_RESET_PLL;
                end
            end
            S_FAIL: begin
                if (bus.req_relock) begin
                    relock_ok = 1'b1;
                    state_nxt = S_RESET_PLL;
                end
            end
            default: state_nxt = S_RESET_PLL;
        endcase
        if (timeout) state_nxt = (retry_q == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RESET_PLL;
            rst_cnt  <= '0;
            filt_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            state <= state_nxt;

            if (state == S_RESET_PLL && state_nxt == S_RESET_PLL) begin
                if (rst_cnt != '1) rst_cnt <= rst_cnt + 1'b1;
            end else begin
                rst_cnt <= '0;
            end

            if (state == S_FILTER && state_nxt == S_FILTER) begin
                if (filt_cnt != '1) filt_cnt <= filt_cnt + 1'b1;
            end else begin
                filt_cnt <= '0;
            end

            // The timeout spans WAIT_LOCK and FILTER, so a lock glitch does not restart it.
            if (win_cur && win_nxt) begin
                if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q     <= 4'd0;
            lock_lost_q <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            if (timeout && state_nxt == S_RESET_PLL) begin
                if (retry_q != 4'hf) retry_q <= retry_q + 4'd1;
            end else if (state_nxt == S_RUN || (state == S_FAIL && relock_ok)) begin
                retry_q <= 4'd0;
            end

            if (lost_evt)       lock_lost_q <= 1'b1;
            else if (relock_ok) lock_lost_q <= 1'b0;

            pll_rst_q   <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAIL);
            sys_rst_n_q <= (state_nxt == S_RUN);
            ready_q     <= (state_nxt == S_RUN);
            fail_q      <= (state_nxt == S_FAIL);
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst_n = sys_rst_n_q;
    assign bus.ready     = ready_q;
    assign bus.fail      = fail_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.retry_cnt = retry_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - scoreboard bench for pll_lock_sequencer against a timeline model
module tb_pll_lock_sequencer;
    localparam int R    = 4;
    localparam int F    = 8;
    localparam int T    = 100;
    localparam int M    = 2;
    localparam int MAXL = 1600;

    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_FAIL = 3;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst_n;
        logic       ready;
        logic       fail;
        logic       lock_lost;
        logic [3:0] retry;
    } out_t;

    typedef struct {
        out_t o;
        int   ep;
        int   idx;
    } exp_t;

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;

    pll_lock_sequencer_if bus();

    pll_lock_sequencer #(
        .RST_CYCLES  (R),
        .LOCK_FILTER (F),
        .LOCK_TIMEOUT(T),
        .MAX_RETRIES (M)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 refclk = ~refclk;

    exp_t exp_q[$];
    bit   lk[MAXL+1];
    bit   rl[MAXL+1];
    out_t exp_out[MAXL+1];
    int   cur_len;
    int   checks = 0;
    int   errors = 0;

    function automatic out_t mk(bit prst, bit run, bit fl, bit lost, int retry);
        out_t o;
        o.pll_rst   = prst;
        o.sys_rst_n = run;
        o.ready     = run;
        o.fail      = fl;
        o.lock_lost = lost;
        o.retry     = 4'(retry);
        return o;
    endfunction

    // Lock as seen by the sequencer at edge t: two edges of synchronizer delay, zero from reset.
    function automatic bit ls(int t);
        return (t <= 2) ? 1'b0 : lk[t-2];
    endfunction

    function automatic bit ones(int a, int b);
        for (int k = a; k <= b; k++) if (!ls(k)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void put(int i, out_t o);
        if (i <= cur_len) exp_out[i] = o;
    endfunction

    // Walks the episode phase by phase, locating each phase end by searching the stimulus.
    task automatic run_model(input int L);
        int t, w, e, f, x, ph, retry;
        bit lost;
        cur_len    = L;
        exp_out[0] = mk(1, 0, 0, 0, 0);
        t = 0; ph = PH_RST; retry = 0; lost = 0;
        while (t < L) begin
            case (ph)
                PH_RST: begin
                    for (int k = t + 1; k < t + R && k <= L; k++) exp_out[k] = mk(1, 0, 0, lost, retry);
                    w = t + R;
                    put(w, mk(0, 0, 0, lost, retry));
                    t = w; ph = PH_WAIT;
                end
                PH_WAIT: begin
                    e = -1;
                    for (int k = t + F + 1; k < t + T && k <= L && e < 0; k++)
                        if (ones(k - F, k)) e = k;
                    x = (e >= 0) ? e : t + T;
                    for (int k = t + 1; k < x && k <= L; k++) exp_out[k] = mk(0, 0, 0, lost, retry);
                    if (e >= 0) begin
                        retry = 0;
                        put(x, mk(0, 1, 0, lost, 0));
                        ph = PH_RUN;
                    end else if (retry == M) begin
                        put(x, mk(1, 0, 1, lost, retry));
                        ph = PH_FAIL;
                    end else begin
                        retry++;
                        put(x, mk(1, 0, 0, lost, retry));
                        ph = PH_RST;
                    end
                    t = x;
                end
                PH_RUN: begin
                    f = -1;
                    for (int k = t + 1; k <= L && f < 0; k++) if (!ls(k) || rl[k]) f = k;
                    x = (f >= 0) ? f : L + 1;
                    for (int k = t + 1; k < x && k <= L; k++) exp_out[k] = mk(0, 1, 0, lost, 0);
                    if (f >= 0) begin
                        lost = !ls(f);
                        put(f, mk(1, 0, 0, lost, 0));
                        ph = PH_RST; t = f;
                    end else t = L;
                end
                default: begin
                    f = -1;
                    for (int k = t + 1; k <= L && f < 0; k++) if (rl[k]) f = k;
                    x = (f >= 0) ? f : L + 1;
                    for (int k = t + 1; k < x && k <= L; k++) exp_out[k] = mk(1, 0, 1, lost, retry);
                    if (f >= 0) begin
                        retry = 0; lost = 0;
                        put(f, mk(1, 0, 0, 0, 0));
                        ph = PH_RST; t = f;
                    end else t = L;
                end
            endcase
        end
    endtask

    task automatic build(input int mode, input int L);
        int t, len, kind;
        bit v;
        for (int k = 0; k <= MAXL; k++) begin lk[k] = 0; rl[k] = 0; end
        case (mode)
            0: for (int k = 1; k <= L; k++) lk[k] = 1;
            1: begin
                for (int k = 1; k <= L; k++) lk[k] = 1;
                lk[9] = 0;
            end
            2: begin
                for (int k = 380; k <= L; k++) lk[k] = 1;
                for (int k = 450; k <= 452; k++) lk[k] = 0;
                rl[300] = 1; rl[350] = 1; rl[460] = 1; rl[520] = 1;
            end
            default: begin
                t = 1;
                while (t <= L) begin
                    kind = $urandom_range(0, 19);
                    if (kind < 9)       begin v = 1; len = $urandom_range(5, 80);    end
                    else if (kind < 15) begin v = 0; len = $urandom_range(1, 3);     end
                    else if (kind < 18) begin v = 0; len = $urandom_range(20, 120);  end
                    else                begin v = 0; len = $urandom_range(300, 420); end
                    for (int k = t; k < t + len && k <= L; k++) lk[k] = v;
                    t += len;
                end
                for (int k = 1; k <= L; k++) rl[k] = ($urandom_range(0, 59) == 0);
            end
        endcase
    endtask

    task automatic push(input out_t o, input int ep, input int idx);
        exp_t e;
        e.o = o; e.ep = ep; e.idx = idx;
        exp_q.push_back(e);
    endtask

    // Async reset lands 2 time units after edge L of the previous episode, before the sample point.
    task automatic play(input int L, input int ep);
        @(posedge refclk); #2;
        rst_n = 0; bus.pll_locked = 0; bus.req_relock = 0;
        push(mk(1, 0, 0, 0, 0), ep, -1);
        repeat (2) begin
            @(posedge refclk); #2;
            push(mk(1, 0, 0, 0, 0), ep, -1);
        end
        @(posedge refclk); #2;
        rst_n = 1; bus.pll_locked = lk[1]; bus.req_relock = rl[1];
        push(exp_out[0], ep, 0);
        for (int t = 1; t < L; t++) begin
            @(posedge refclk); #2;
            bus.pll_locked = lk[t+1]; bus.req_relock = rl[t+1];
            push(exp_out[t], ep, t);
        end
    endtask

    initial begin
        exp_t e;
        out_t a;
        forever begin
            @(negedge refclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.pll_rst, bus.sys_rst_n, bus.ready, bus.fail, bus.lock_lost, bus.retry_cnt};
                checks++;
                if (a !== e.o) begin
                    errors++;
                    $display("FAIL outputs ep%0d edge%0d: got pll_rst=%b sys_rst_n=%b ready=%b fail=%b lock_lost=%b retry_cnt=%0d, expected pll_rst=%b sys_rst_n=%b ready=%b fail=%b lock_lost=%b retry_cnt=%0d",
                             e.ep, e.idx, a.pll_rst, a.sys_rst_n, a.ready, a.fail, a.lock_lost, a.retry,
                             e.o.pll_rst, e.o.sys_rst_n, e.o.ready, e.o.fail, e.o.lock_lost, e.o.retry);
                end
            end
        end
    end

    initial begin
        int modes[9];
        int lens[9];
        modes = '{0, 0, 1, 2, 3, 3, 3, 3, 3};
        lens  = '{10, 30, 40, 560, 0, 0, 0, 0, 0};
        bus.pll_locked = 0;
        bus.req_relock = 0;
        for (int ep = 0; ep < 9; ep++) begin
            if (lens[ep] == 0) lens[ep] = $urandom_range(800, 1400);
            build(modes[ep], lens[ep]);
            run_model(lens[ep]);
            play(lens[ep], ep);
        end
        @(posedge refclk); #2;
        rst_n = 0;
        push(mk(1, 0, 0, 0, 0), 99, -1);
        repeat (3) @(posedge refclk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
